cond_ctrl_pipe: RTL and testbench

Parametrised control-signal pipeline for the pipelined ARM-subset core. It takes decoded control from the Decode stage and carries it through Execute, where conditional execution is evaluated against a registered NZCV flags register. It then carries the gated control through N_POST post-execute stages, ending at Writeback. It adds stall-with-bubble, a configurable post-execute depth, a generic side-band control bundle, a full 16-code condition unit and an in-flight PC-write counter for the hazard unit.

---
 rtl/cond_ctrl_pipe.sv | 192 +++++++++++++++++++
 tb/tb_cond_ctrl_pipe.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_ctrl_pipe.sv
// Control-signal pipeline from Decode through Execute to Writeback.
// Execute holds the decoded control and evaluates the condition field against the
// committed NZCV flags. Only control whose condition passes moves on as a write.
// Stage 1 is Memory and stage N_POST is Writeback.
// The block also counts the PC writes still in flight, for the hazard unit.
module cond_ctrl_pipe #(
    parameter int unsigned CTRL_W = 6,
    parameter int unsigned N_POST = 2
) (
    input  logic              clk,
    input  logic              reset,
    // Decode-stage control
    input  logic              pcs_d,
    input  logic              regw_d,
    input  logic              memw_d,
    input  logic              branch_d,
    input  logic [1:0]        flagw_d,
    input  logic [3:0]        cond_d,
    input  logic [CTRL_W-1:0] side_d,
    // Execute-stage inputs
    input  logic [3:0]        alu_flags,
    input  logic              stall_e,
    input  logic              flush_e,
    // Execute-stage outputs
    output logic [CTRL_W-1:0] side_e,
    output logic [3:0]        flags_q,
    output logic              cond_ex_e,
    output logic              branch_taken_e,
    // Memory stage (stage 1)
    output logic              regwrite_m,
    output logic              memwrite_m,
    output logic [CTRL_W-1:0] side_m,
    // Writeback stage (stage N_POST)
    output logic              pcsrc_w,
    output logic              regwrite_w,
    output logic [CTRL_W-1:0] side_w,
    // Hazard-unit view of PC writes still in flight
    output logic              pcwr_pending_f,
    output logic [2:0]        pcwr_count
);

    // Execute register
    logic              pcsE;
    logic              regwE;
    logic              memwE;
    logic              branchE;
    logic [1:0]        flagwE;
    logic [3:0]        condE;
    logic [CTRL_W-1:0] sideE;

    // Condition result and the writes it gates
    logic condEx;
    logic pcsrcE;
    logic regwG;
    logic memwG;

    // Flag bits, named for readability
    logic flagN;
    logic flagZ;
    logic flagC;
    logic flagV;

    // Post-execute stages. Index 1 is Memory and index N_POST is Writeback.
    logic [N_POST:1]             pcsrcS;
    logic [N_POST:1]             regwS;
    logic                        memwM;
    logic [N_POST:1][CTRL_W-1:0] sideS;

    logic [2:0] pcwrCount;

    assign flagN = flags_q[3];
    assign flagZ = flags_q[2];
    assign flagC = flags_q[1];
    assign flagV = flags_q[0];

    // Decode the 16 condition codes against the committed flags
    always_comb begin
        condEx = 1'b0;
        unique case (condE)
            4'd0:  condEx = flagZ;
            4'd1:  condEx = !flagZ;
            4'd2:  condEx = flagC;
            4'd3:  condEx = !flagC;
            4'd4:  condEx = flagN;
            4'd5:  condEx = !flagN;
            4'd6:  condEx = flagV;
            4'd7:  condEx = !flagV;
            4'd8:  condEx = flagC && !flagZ;
            4'd9:  condEx = !flagC || flagZ;
            4'd10: condEx = (flagN == flagV);
            4'd11: condEx = (flagN != flagV);
            4'd12: condEx = !flagZ && (flagN == flagV);
            4'd13: condEx = flagZ || (flagN != flagV);
            4'd14: condEx = 1'b1;
            4'd15: condEx = 1'b0;
        endcase
    end

    assign pcsrcE = pcsE & condEx;
    assign regwG  = regwE & condEx;
    assign memwG  = memwE & condEx;

    // Execute register: flush beats stall, and stall beats load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcsE    <= 1'b0;
            regwE   <= 1'b0;
            memwE   <= 1'b0;
            branchE <= 1'b0;
            flagwE  <= 2'b00;
            condE   <= 4'd0;
            sideE   <= '0;
        end else if (flush_e) begin
            pcsE    <= 1'b0;
            regwE   <= 1'b0;
            memwE   <= 1'b0;
            branchE <= 1'b0;
            flagwE  <= 2'b00;
            condE   <= 4'd0;
            sideE   <= '0;
        end else if (!stall_e) begin
            pcsE    <= pcs_d;
            regwE   <= regw_d;
            memwE   <= memw_d;
            branchE <= branch_d;
            flagwE  <= flagw_d;
            condE   <= cond_d;
            sideE   <= side_d;
        end
    end

    // NZCV commit. A flush of E does not cancel the update for the instruction already in E.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (!stall_e && condEx) begin
            if (flagwE[1]) begin
                flags_q[3:2] <= alu_flags[3:2];
            end
            if (flagwE[0]) begin
                flags_q[1:0] <= alu_flags[1:0];
            end
        end
    end

    // Post-execute shift chain. A held E instruction sends a bubble so it issues only once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcsrcS <= '0;
            regwS  <= '0;
            memwM  <= 1'b0;
            sideS  <= '0;
        end else begin
            if (stall_e) begin
                pcsrcS[1] <= 1'b0;
                regwS[1]  <= 1'b0;
                memwM     <= 1'b0;
            end else begin
                pcsrcS[1] <= pcsrcE;
                regwS[1]  <= regwG;
                memwM     <= memwG;
            end
            sideS[1] <= sideE;
            for (int i = 2; i <= int'(N_POST); i++) begin
                pcsrcS[i] <= pcsrcS[i-1];
                regwS[i]  <= regwS[i-1];
                sideS[i]  <= sideS[i-1];
            end
        end
    end

    // PC writes in flight: D and E (ungated), plus every stage before W
    always_comb begin
        pcwrCount = {2'b00, pcs_d} + {2'b00, pcsE};
        for (int i = 1; i < int'(N_POST); i++) begin
            pcwrCount = pcwrCount + {2'b00, pcsrcS[i]};
        end
    end

    assign side_e         = sideE;
    assign cond_ex_e      = condEx;
    assign branch_taken_e = branchE & condEx;
    assign regwrite_m     = regwS[1];
    assign memwrite_m     = memwM;
    assign side_m         = sideS[1];
    assign pcsrc_w        = pcsrcS[N_POST];
    assign regwrite_w     = regwS[N_POST];
    assign side_w         = sideS[N_POST];
    assign pcwr_count     = pcwrCount;
    assign pcwr_pending_f = (pcwrCount != 3'd0);

endmodule

// File: tb/tb_cond_ctrl_pipe.sv
// Self-checking bench for cond_ctrl_pipe. It uses a queue-based reference model,
// a condition-code vector table, hand-written corner sequences and random traffic.
module tb_cond_ctrl_pipe;

    localparam int CTRL_W = 6;
    localparam int N_POST = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              pcs_d = 1'b0;
    logic              regw_d = 1'b0;
    logic              memw_d = 1'b0;
    logic              branch_d = 1'b0;
    logic [1:0]        flagw_d = '0;
    logic [3:0]        cond_d = '0;
    logic [CTRL_W-1:0] side_d = '0;
    logic [3:0]        alu_flags = '0;
    logic              stall_e = 1'b0;
    logic              flush_e = 1'b0;
    logic [CTRL_W-1:0] side_e;
    logic [3:0]        flags_q;
    logic              cond_ex_e;
    logic              branch_taken_e;
    logic              regwrite_m;
    logic              memwrite_m;
    logic [CTRL_W-1:0] side_m;
    logic              pcsrc_w;
    logic              regwrite_w;
    logic [CTRL_W-1:0] side_w;
    logic              pcwr_pending_f;
    logic [2:0]        pcwr_count;

    cond_ctrl_pipe #(
        .CTRL_W(CTRL_W),
        .N_POST(N_POST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pcs_d         (pcs_d),
        .regw_d        (regw_d),
        .memw_d        (memw_d),
        .branch_d      (branch_d),
        .flagw_d       (flagw_d),
        .cond_d        (cond_d),
        .side_d        (side_d),
        .alu_flags     (alu_flags),
        .stall_e       (stall_e),
        .flush_e       (flush_e),
        .side_e        (side_e),
        .flags_q       (flags_q),
        .cond_ex_e     (cond_ex_e),
        .branch_taken_e(branch_taken_e),
        .regwrite_m    (regwrite_m),
        .memwrite_m    (memwrite_m),
        .side_m        (side_m),
        .pcsrc_w       (pcsrc_w),
        .regwrite_w    (regwrite_w),
        .side_w        (side_w),
        .pcwr_pending_f(pcwr_pending_f),
        .pcwr_count    (pcwr_count)
    );

    always #5 clk = ~clk;

    int passCnt = 0;
    int totalCnt = 0;

    // Reference model: one instruction record in E, and a queue of post-E records (front = M)
    typedef struct {
        logic              pcs;
        logic              regw;
        logic              memw;
        logic              branch;
        logic [1:0]        flagw;
        logic [3:0]        cond;
        logic [CTRL_W-1:0] side;
    } instrT;

    typedef struct {
        logic              pcsrc;
        logic              regw;
        logic              memw;
        logic [CTRL_W-1:0] side;
    } postT;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] flags;
        logic       pass;
    } condVecT;

    instrT      mE;
    postT       mPost[$];
    logic [3:0] mFlags;

    // Codes 0..13 come in pairs, and the odd code of each pair is the inverse of the even one
    function automatic logic condPass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3];
        z = f[2];
        cy = f[1];
        v = f[0];
        if (c == 4'd14) return 1'b1;
        if (c == 4'd15) return 1'b0;
        case (c >> 1)
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            default: base = ~z & (n == v);
        endcase
        return base ^ c[0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mE = '{default: '0};
        mPost.delete();
        for (int i = 0; i < N_POST; i++) mPost.push_back('{default: '0});
        mFlags = 4'b0000;
    endtask

    // Advance the model across one rising edge, using the inputs held at that edge
    task automatic modelStep();
        logic ok;
        postT s;
        ok = condPass(mE.cond, mFlags);
        s.side = mE.side;
        s.pcsrc = stall_e ? 1'b0 : (mE.pcs & ok);
        s.regw = stall_e ? 1'b0 : (mE.regw & ok);
        s.memw = stall_e ? 1'b0 : (mE.memw & ok);
        if (!stall_e && ok) begin
            if (mE.flagw[1]) mFlags[3:2] = alu_flags[3:2];
            if (mE.flagw[0]) mFlags[1:0] = alu_flags[1:0];
        end
        mPost.push_front(s);
        void'(mPost.pop_back());
        if (flush_e) begin
            mE = '{default: '0};
        end else if (!stall_e) begin
            mE.pcs = pcs_d;
            mE.regw = regw_d;
            mE.memw = memw_d;
            mE.branch = branch_d;
            mE.flagw = flagw_d;
            mE.cond = cond_d;
            mE.side = side_d;
        end
    endtask

    task automatic checkAll();
        logic ok;
        int cnt;
        ok = condPass(mE.cond, mFlags);
        cnt = int'(pcs_d) + int'(mE.pcs);
        for (int i = 0; i < N_POST - 1; i++) cnt += int'(mPost[i].pcsrc);
        chk("cond_ex_e", cond_ex_e, ok);
        chk("branch_taken_e", branch_taken_e, mE.branch & ok);
        chk("flags_q", flags_q, mFlags);
        chk("side_e", side_e, mE.side);
        chk("regwrite_m", regwrite_m, mPost[0].regw);
        chk("memwrite_m", memwrite_m, mPost[0].memw);
        chk("side_m", side_m, mPost[0].side);
        chk("pcsrc_w", pcsrc_w, mPost[N_POST-1].pcsrc);
        chk("regwrite_w", regwrite_w, mPost[N_POST-1].regw);
        chk("side_w", side_w, mPost[N_POST-1].side);
        chk("pcwr_count", pcwr_count, cnt);
        chk("pcwr_pending_f", pcwr_pending_f, cnt != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic setD(input logic pcs, input logic regw, input logic memw, input logic br,
                        input logic [1:0] fw, input logic [3:0] c, input logic [CTRL_W-1:0] sd);
        pcs_d = pcs;
        regw_d = regw;
        memw_d = memw;
        branch_d = br;
        flagw_d = fw;
        cond_d = c;
        side_d = sd;
    endtask

    task automatic clearD();
        setD(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, '0);
    endtask

    // Pulse the reset between clock edges
    task automatic doReset();
        clearD();
        stall_e = 1'b0;
        flush_e = 1'b0;
        alu_flags = 4'b0000;
        reset = 1'b1;
        #1;
        modelReset();
        #1;
        reset = 1'b0;
        #1;
    endtask

    condVecT vt[18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{4'd0,  4'b0100, 1'b1};
        vt[1]  = '{4'd1,  4'b0100, 1'b0};
        vt[2]  = '{4'd2,  4'b0010, 1'b1};
        vt[3]  = '{4'd3,  4'b0010, 1'b0};
        vt[4]  = '{4'd4,  4'b1000, 1'b1};
        vt[5]  = '{4'd5,  4'b1000, 1'b0};
        vt[6]  = '{4'd6,  4'b0001, 1'b1};
        vt[7]  = '{4'd7,  4'b0001, 1'b0};
        vt[8]  = '{4'd8,  4'b0010, 1'b1};
        vt[9]  = '{4'd8,  4'b0110, 1'b0};
        vt[10] = '{4'd9,  4'b0110, 1'b1};
        vt[11] = '{4'd10, 4'b1001, 1'b1};
        vt[12] = '{4'd11, 4'b1000, 1'b1};
        vt[13] = '{4'd12, 4'b0100, 1'b0};
        vt[14] = '{4'd12, 4'b0000, 1'b1};
        vt[15] = '{4'd13, 4'b0001, 1'b1};
        vt[16] = '{4'd14, 4'b1111, 1'b1};
        vt[17] = '{4'd15, 4'b0000, 1'b0};

        reset = 1'b1;
        modelReset();
        #2;
        chk("reset_flags", flags_q, 0);
        chk("reset_regwrite_m", regwrite_m, 0);
        chk("reset_pcsrc_w", pcsrc_w, 0);
        reset = 1'b0;
        #1;

        // Condition table: set the flags with an AL instruction, then evaluate the code in E
        foreach (vt[k]) begin
            doReset();
            setD(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'd14, '0);
            alu_flags = vt[k].flags;
            tick();
            setD(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, vt[k].cond, 6'h2a);
            tick();
            clearD();
            chk($sformatf("cond_tbl_%0d_flags", k), flags_q, vt[k].flags);
            chk($sformatf("cond_tbl_%0d", k), cond_ex_e, vt[k].pass);
            tick();
            chk($sformatf("cond_tbl_%0d_regw_m", k), regwrite_m, vt[k].pass);
        end

        // Reset mid-stream: fill the pipe, then check that every output clears before the next edge
        doReset();
        setD(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 4'd14, 6'h15);
        alu_flags = 4'b1111;
        for (int i = 0; i < N_POST + 1; i++) tick();
        chk("pre_rst_regw_m", regwrite_m, 1);
        chk("pre_rst_pcsrc_w", pcsrc_w, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_regwrite_m", regwrite_m, 0);
        chk("rst_memwrite_m", memwrite_m, 0);
        chk("rst_pcsrc_w", pcsrc_w, 0);
        chk("rst_flags_q", flags_q, 0);
        chk("rst_side_w", side_w, 0);
        modelReset();
        clearD();
        alu_flags = 4'b0000;
        #1;
        reset = 1'b0;
        #1;

        // Set the flags, then run a dependent EQ instruction
        doReset();
        setD(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'd14, '0);
        tick();
        alu_flags = 4'b0100;
        setD(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 6'h07);
        tick();
        clearD();
        chk("dep_flags", flags_q, 4'b0100);
        chk("dep_cond_ex", cond_ex_e, 1);
        tick();
        chk("dep_regw_m", regwrite_m, 1);
        for (int i = 1; i < N_POST; i++) tick();
        chk("dep_regw_w", regwrite_w, 1);
        chk("dep_side_w", side_w, 6'h07);

        // Failing condition: the writes are gated and the flags stay unchanged
        setD(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 4'd1, '0);
        tick();
        clearD();
        alu_flags = 4'b1011;
        chk("fail_cond_ex", cond_ex_e, 0);
        tick();
        chk("fail_regw_m", regwrite_m, 0);
        chk("fail_memw_m", memwrite_m, 0);
        chk("fail_flags", flags_q, 4'b0100);
        doReset();
        setD(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 4'd15, '0);
        tick();
        clearD();
        chk("nv_cond_ex", cond_ex_e, 0);
        chk("nv_branch", branch_taken_e, 0);
        tick();
        chk("nv_regw_m", regwrite_m, 0);
        chk("nv_memw_m", memwrite_m, 0);

        // Taken branch: track the in-flight PC-write count down to W
        doReset();
        setD(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'd14, '0);
        #1;
        chk("br_count_d", pcwr_count, 1);
        tick();
        clearD();
        #1;
        chk("br_count_e", pcwr_count, 1);
        chk("br_taken", branch_taken_e, 1);
        for (int i = 1; i < N_POST; i++) begin
            tick();
            chk($sformatf("br_count_s%0d", i), pcwr_count, 1);
            chk($sformatf("br_pend_s%0d", i), pcwr_pending_f, 1);
        end
        tick();
        chk("br_count_w", pcwr_count, 0);
        chk("br_pend_w", pcwr_pending_f, 0);
        chk("br_pcsrc_w", pcsrc_w, 1);

        // Flush loads a bubble; flush also wins over stall
        doReset();
        setD(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'd14, 6'h3f);
        flush_e = 1'b1;
        tick();
        flush_e = 1'b0;
        clearD();
        chk("flush_side_e", side_e, 0);
        tick();
        chk("flush_regw_m", regwrite_m, 0);
        chk("flush_memw_m", memwrite_m, 0);
        setD(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'd14, 6'h11);
        tick();
        chk("pre_fs_side_e", side_e, 6'h11);
        stall_e = 1'b1;
        flush_e = 1'b1;
        tick();
        stall_e = 1'b0;
        flush_e = 1'b0;
        clearD();
        chk("fs_side_e", side_e, 0);

        // Stall: memory write issues once after release, and C,V update once
        doReset();
        setD(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 4'd14, 6'h05);
        tick();
        clearD();
        stall_e = 1'b1;
        alu_flags = 4'b1111;
        tick();
        chk("stall1_memw_m", memwrite_m, 0);
        chk("stall1_flags", flags_q, 0);
        tick();
        chk("stall2_memw_m", memwrite_m, 0);
        chk("stall2_flags", flags_q, 0);
        stall_e = 1'b0;
        tick();
        chk("rel_memw_m", memwrite_m, 1);
        chk("rel_flags", flags_q, 4'b0011);
        tick();
        chk("post_memw_m", memwrite_m, 0);
        chk("post_flags", flags_q, 4'b0011);

        // Random traffic against the model
        doReset();
        for (int n = 0; n < 400; n++) begin
            setD(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                 4'($urandom), 6'($urandom));
            alu_flags = 4'($urandom);
            stall_e = ($urandom_range(0, 4) == 0);
            flush_e = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
